// File: rtl/mem_access_pkg.sv
// Shared instruction-field helpers, memory-op opcodes, FSM states and load types
// for the MEM-stage load/store unit.
package mem_access_pkg;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_H  = 3'd1,
        LD_HU = 3'd2,
        LD_B  = 3'd3,
        LD_BU = 3'd4
    } ld_type_t;

    typedef struct packed {
        logic     is_mem;
        logic     is_load;
        ld_type_t ltype;
    } mem_dec_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] ins);
        return ins[OPCODE_HI:OPCODE_LO];
    endfunction

    // Stores reuse the load-type field for their access size (W, H or B).
    function automatic mem_dec_t decode_mem(input logic [5:0] op);
        mem_dec_t d;
        d.is_mem  = 1'b1;
        d.is_load = 1'b1;
        d.ltype   = LD_W;
        case (op)
            OP_LW:   d.ltype = LD_W;
            OP_LH:   d.ltype = LD_H;
            OP_LHU:  d.ltype = LD_HU;
            OP_LB:   d.ltype = LD_B;
            OP_LBU:  d.ltype = LD_BU;
            OP_SW:   d.is_load = 1'b0;
            OP_SH: begin
                d.is_load = 1'b0;
                d.ltype   = LD_H;
            end
            OP_SB: begin
                d.is_load = 1'b0;
                d.ltype   = LD_B;
            end
            default: begin
                d.is_mem  = 1'b0;
                d.is_load = 1'b0;
            end
        endcase
        return d;
    endfunction

    function automatic logic addr_ok(input ld_type_t t, input logic [1:0] a);
        logic ok;
        case (t)
            LD_W:        ok = (a == 2'b00);
            LD_H, LD_HU: ok = ~a[0];
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byteen_for(input ld_type_t t, input logic [1:0] a);
        logic [3:0] be;
        case (t)
            LD_W:        be = 4'b1111;
            LD_H, LD_HU: be = a[1] ? 4'b1100 : 4'b0011;
            default:     be = 4'b0001 << a;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] replicate(input ld_type_t t, input logic [31:0] d);
        logic [31:0] r;
        case (t)
            LD_H, LD_HU: r = {2{d[15:0]}};
            LD_B, LD_BU: r = {4{d[7:0]}};
            default:     r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Combinational lane selection and sign/zero extension of a read word.
module load_ext
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  ld_type_t    ltype,
    output logic [31:0] data
);

    logic [15:0] half;
    logic [7:0]  byte_lane;

    always_comb begin
        half      = addr[1] ? word[31:16] : word[15:0];
        byte_lane = 8'h00;
        case (addr)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase

        case (ltype)
            LD_H:    data = {{16{half[15]}}, half};
            LD_HU:   data = {16'h0000, half};
            LD_B:    data = {{24{byte_lane[7]}}, byte_lane};
            LD_BU:   data = {24'h000000, byte_lane};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: decodes memory ops, runs a two-state bus handshake,
// stalls the pipeline while the bus is busy and reports address errors.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        M_valid,
    input  logic [31:0] M_ins,
    input  logic [31:0] M_PC,
    input  logic [31:0] M_alu_res,
    input  logic [31:0] M_reg_rt,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        M_stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic [31:0] exc_pc
);

    state_t      state;
    mem_dec_t    dec;
    logic        aligned;
    logic        issue;
    logic        fault;
    logic [31:0] addr_q;
    ld_type_t    ltype_q;
    logic        is_load_q;
    logic [31:0] ext_data;
    logic        unused_ins_bits;

    assign dec             = decode_mem(opcode_of(M_ins));
    assign aligned         = addr_ok(dec.ltype, M_alu_res[1:0]);
    assign issue           = (state == ST_IDLE) && M_valid && dec.is_mem && aligned;
    assign fault           = (state == ST_IDLE) && M_valid && dec.is_mem && !aligned;
    assign unused_ins_bits = ^M_ins[OPCODE_LO-1:0];

    // The issue cycle stalls before the FSM has even left IDLE, so M_stall is
    // combinational; it is gated by reset so a held instruction cannot stall.
    assign M_stall  = reset_n && (issue || ((state == ST_BUSY) && !mem_ready));
    assign mem_addr = {addr_q[31:2], 2'b00};

    load_ext u_load_ext (
        .word  (mem_rdata),
        .addr  (addr_q[1:0]),
        .ltype (ltype_q),
        .data  (ext_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            addr_q     <= '0;
            mem_wdata  <= '0;
            mem_byteen <= '0;
            ltype_q    <= LD_W;
            is_load_q  <= 1'b0;
            ld_valid   <= 1'b0;
            ld_data    <= '0;
            exc_adel   <= 1'b0;
            exc_ades   <= 1'b0;
            exc_pc     <= '0;
        end else begin
            ld_valid <= 1'b0;
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        state      <= ST_BUSY;
                        mem_req    <= 1'b1;
                        mem_we     <= ~dec.is_load;
                        addr_q     <= M_alu_res;
                        mem_wdata  <= replicate(dec.ltype, M_reg_rt);
                        mem_byteen <= byteen_for(dec.ltype, M_alu_res[1:0]);
                        ltype_q    <= dec.ltype;
                        is_load_q  <= dec.is_load;
                    end else if (fault) begin
                        exc_adel <= dec.is_load;
                        exc_ades <= ~dec.is_load;
                        exc_pc   <= M_PC;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (is_load_q) begin
                            ld_valid <= 1'b1;
                            ld_data  <= ext_data;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: loads, stores, extension,
// address errors, reset during a transaction and back-to-back ops.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        M_valid;
    logic [31:0] M_ins;
    logic [31:0] M_PC;
    logic [31:0] M_alu_res;
    logic [31:0] M_reg_rt;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        M_stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        exc_adel;
    logic        exc_ades;
    logic [31:0] exc_pc;

    int total = 0;
    int bad   = 0;

    mem_access dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .M_valid    (M_valid),
        .M_ins      (M_ins),
        .M_PC       (M_PC),
        .M_alu_res  (M_alu_res),
        .M_reg_rt   (M_reg_rt),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_byteen (mem_byteen),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .M_stall    (M_stall),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .exc_adel   (exc_adel),
        .exc_ades   (exc_ades),
        .exc_pc     (exc_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] rt, input logic [31:0] pc);
        M_valid   = 1'b1;
        M_ins     = {op, 26'h0};
        M_alu_res = addr;
        M_reg_rt  = rt;
        M_PC      = pc;
    endtask

    task automatic drop();
        M_valid = 1'b0;
        M_ins   = 32'h0;
    endtask

    // Issue a load, complete it at minimum latency, and leave just after the completing edge.
    task automatic load_min(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rdata);
        issue(op, addr, 32'h0, 32'h0000_0500);
        tick();
        mem_ready = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ready = 1'b0;
        drop();
    endtask

    task automatic test_reset();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", mem_we); end
        total++; if (M_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", M_stall); end
        total++; if (ld_valid !== 1'b0) begin bad++; $display("FAIL rst_ldv: got %b want 0", ld_valid); end
        total++; if ({exc_adel, exc_ades} !== 2'b00) begin bad++; $display("FAIL rst_exc: got %b want 00", {exc_adel, exc_ades}); end
        total++; if ({mem_addr, mem_wdata, ld_data, exc_pc} !== 128'h0) begin bad++; $display("FAIL rst_data: addr=%h wdata=%h ld=%h pc=%h want 0", mem_addr, mem_wdata, ld_data, exc_pc); end
        total++; if (mem_byteen !== 4'b0000) begin bad++; $display("FAIL rst_be: got %b want 0000", mem_byteen); end
    endtask

    task automatic test_lw_wait();
        issue(OP_LW, 32'h0000_1004, 32'h0, 32'h0000_0400);
        #1;
        total++; if (M_stall !== 1'b1) begin bad++; $display("FAIL lw_stall0: got %b want 1", M_stall); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL lw_req0: got %b want 0", mem_req); end
        tick();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL lw_req1: got %b want 1", mem_req); end
        total++; if (mem_addr !== 32'h0000_1004) begin bad++; $display("FAIL lw_addr: got %h want 00001004", mem_addr); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL lw_we: got %b want 0", mem_we); end
        total++; if (mem_byteen !== 4'b1111) begin bad++; $display("FAIL lw_be: got %b want 1111", mem_byteen); end
        total++; if (M_stall !== 1'b1) begin bad++; $display("FAIL lw_stall1: got %b want 1", M_stall); end
        tick();
        total++; if ({mem_req, M_stall} !== 2'b11) begin bad++; $display("FAIL lw_stall2: req/stall got %b want 11", {mem_req, M_stall}); end
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (M_stall !== 1'b0) begin bad++; $display("FAIL lw_stall3: got %b want 0", M_stall); end
        tick();
        mem_ready = 1'b0;
        drop();
        total++; if (ld_valid !== 1'b1) begin bad++; $display("FAIL lw_ldv: got %b want 1", ld_valid); end
        total++; if (ld_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data: got %h want deadbeef", ld_data); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL lw_req_done: got %b want 0", mem_req); end
        tick();
        total++; if (ld_valid !== 1'b0) begin bad++; $display("FAIL lw_ldv_pulse: got %b want 0", ld_valid); end
    endtask

    task automatic test_extend();
        load_min(OP_LB, 32'h0000_1003, 32'h8012_3456);
        total++; if ({ld_valid, ld_data} !== {1'b1, 32'hFFFF_FF80}) begin bad++; $display("FAIL lb: got v=%b %h want v=1 ffffff80", ld_valid, ld_data); end
        load_min(OP_LBU, 32'h0000_1003, 32'h8012_3456);
        total++; if ({ld_valid, ld_data} !== {1'b1, 32'h0000_0080}) begin bad++; $display("FAIL lbu: got v=%b %h want v=1 00000080", ld_valid, ld_data); end
        load_min(OP_LB, 32'h0000_1001, 32'h8012_3456);
        total++; if (ld_data !== 32'h0000_0034) begin bad++; $display("FAIL lb_pos: got %h want 00000034", ld_data); end
        load_min(OP_LH, 32'h0000_1002, 32'h8001_7FFF);
        total++; if (ld_data !== 32'hFFFF_8001) begin bad++; $display("FAIL lh: got %h want ffff8001", ld_data); end
        load_min(OP_LHU, 32'h0000_1002, 32'h8001_7FFF);
        total++; if (ld_data !== 32'h0000_8001) begin bad++; $display("FAIL lhu: got %h want 00008001", ld_data); end
        load_min(OP_LH, 32'h0000_1000, 32'h8001_7FFF);
        total++; if (ld_data !== 32'h0000_7FFF) begin bad++; $display("FAIL lh_low: got %h want 00007fff", ld_data); end
    endtask

    task automatic test_store();
        issue(OP_SH, 32'h0000_1002, 32'h0000_ABCD, 32'h0000_0600);
        tick();
        total++; if (mem_byteen !== 4'b1100) begin bad++; $display("FAIL sh_be: got %b want 1100", mem_byteen); end
        total++; if (mem_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata: got %h want abcdabcd", mem_wdata); end
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL sh_we: got %b want 1", mem_we); end
        total++; if (mem_addr !== 32'h0000_1000) begin bad++; $display("FAIL sh_addr: got %h want 00001000", mem_addr); end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        drop();
        total++; if ({ld_valid, mem_we, mem_req} !== 3'b000) begin bad++; $display("FAIL sh_done: ldv/we/req got %b want 000", {ld_valid, mem_we, mem_req}); end
        issue(OP_SB, 32'h0000_1001, 32'h1234_56A5, 32'h0000_0604);
        tick();
        total++; if ({mem_byteen, mem_wdata} !== {4'b0010, 32'hA5A5_A5A5}) begin bad++; $display("FAIL sb: be=%b wdata=%h want 0010 a5a5a5a5", mem_byteen, mem_wdata); end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        drop();
        total++; if (ld_valid !== 1'b0) begin bad++; $display("FAIL sb_ldv: got %b want 0", ld_valid); end
    endtask

    task automatic test_misaligned();
        issue(OP_LW, 32'h0000_1001, 32'h0, 32'h0000_0700);
        #1;
        total++; if ({M_stall, mem_req} !== 2'b00) begin bad++; $display("FAIL adel_stall: stall/req got %b want 00", {M_stall, mem_req}); end
        tick();
        drop();
        total++; if ({exc_adel, exc_ades} !== 2'b10) begin bad++; $display("FAIL adel: got %b want 10", {exc_adel, exc_ades}); end
        total++; if (exc_pc !== 32'h0000_0700) begin bad++; $display("FAIL adel_pc: got %h want 00000700", exc_pc); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL adel_req: got %b want 0", mem_req); end
        tick();
        total++; if ({exc_adel, mem_req} !== 2'b00) begin bad++; $display("FAIL adel_pulse: adel/req got %b want 00", {exc_adel, mem_req}); end
        issue(OP_SH, 32'h0000_1001, 32'h0000_1111, 32'h0000_0704);
        #1;
        total++; if (M_stall !== 1'b0) begin bad++; $display("FAIL ades_stall: got %b want 0", M_stall); end
        tick();
        drop();
        total++; if ({exc_adel, exc_ades} !== 2'b01) begin bad++; $display("FAIL ades: got %b want 01", {exc_adel, exc_ades}); end
        total++; if (exc_pc !== 32'h0000_0704) begin bad++; $display("FAIL ades_pc: got %h want 00000704", exc_pc); end
        tick();
        total++; if ({exc_ades, mem_req} !== 2'b00) begin bad++; $display("FAIL ades_pulse: ades/req got %b want 00", {exc_ades, mem_req}); end
    endtask

    task automatic test_ready_idle();
        mem_ready = 1'b1;
        mem_rdata = 32'h1357_9BDF;
        tick();
        mem_ready = 1'b0;
        total++; if ({ld_valid, mem_req, M_stall} !== 3'b000) begin bad++; $display("FAIL idle_ready: ldv/req/stall got %b want 000", {ld_valid, mem_req, M_stall}); end
    endtask

    task automatic test_reset_busy();
        issue(OP_LW, 32'h0000_3008, 32'h0, 32'h0000_0800);
        tick();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rb_req: got %b want 1", mem_req); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if ({mem_req, mem_we, M_stall} !== 3'b000) begin bad++; $display("FAIL rb_ctl: req/we/stall got %b want 000", {mem_req, mem_we, M_stall}); end
        total++; if ({mem_addr, mem_byteen} !== 36'h0) begin bad++; $display("FAIL rb_bus: addr=%h be=%b want 0", mem_addr, mem_byteen); end
        drop();
        tick();
        tick();
        reset_n = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ready = 1'b0;
        total++; if ({ld_valid, mem_req, M_stall} !== 3'b000) begin bad++; $display("FAIL rb_stray: ldv/req/stall got %b want 000", {ld_valid, mem_req, M_stall}); end
        total++; if (ld_data !== 32'h0) begin bad++; $display("FAIL rb_lddata: got %h want 0", ld_data); end
        tick();
        total++; if (ld_valid !== 1'b0) begin bad++; $display("FAIL rb_ldv2: got %b want 0", ld_valid); end
    endtask

    task automatic test_back_to_back();
        issue(OP_SW, 32'h0000_2000, 32'h1234_5678, 32'h0000_0900);
        #1;
        total++; if (M_stall !== 1'b1) begin bad++; $display("FAIL b2b_sw_stall: got %b want 1", M_stall); end
        tick();
        total++; if ({mem_req, mem_we, mem_byteen} !== 6'b11_1111) begin bad++; $display("FAIL b2b_sw_ctl: req/we/be got %b want 111111", {mem_req, mem_we, mem_byteen}); end
        total++; if ({mem_addr, mem_wdata} !== {32'h0000_2000, 32'h1234_5678}) begin bad++; $display("FAIL b2b_sw_bus: addr=%h wdata=%h want 00002000 12345678", mem_addr, mem_wdata); end
        mem_ready = 1'b1;
        #1;
        total++; if (M_stall !== 1'b0) begin bad++; $display("FAIL b2b_sw_release: got %b want 0", M_stall); end
        tick();
        mem_ready = 1'b0;
        issue(OP_LW, 32'h0000_2004, 32'h0, 32'h0000_0904);
        #1;
        total++; if ({mem_req, M_stall} !== 2'b01) begin bad++; $display("FAIL b2b_gap: req/stall got %b want 01", {mem_req, M_stall}); end
        total++; if (ld_valid !== 1'b0) begin bad++; $display("FAIL b2b_sw_ldv: got %b want 0", ld_valid); end
        tick();
        total++; if ({mem_req, mem_we, mem_byteen} !== 6'b10_1111) begin bad++; $display("FAIL b2b_lw_ctl: req/we/be got %b want 101111", {mem_req, mem_we, mem_byteen}); end
        total++; if (mem_addr !== 32'h0000_2004) begin bad++; $display("FAIL b2b_lw_addr: got %h want 00002004", mem_addr); end
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ready = 1'b0;
        drop();
        total++; if ({ld_valid, ld_data} !== {1'b1, 32'hCAFE_F00D}) begin bad++; $display("FAIL b2b_lw_data: v=%b %h want v=1 cafef00d", ld_valid, ld_data); end
    endtask

    initial begin
        reset_n   = 1'b0;
        M_valid   = 1'b0;
        M_ins     = 32'h0;
        M_PC      = 32'h0;
        M_alu_res = 32'h0;
        M_reg_rt  = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        #3;
        test_reset();
        tick();
        reset_n = 1'b1;
        tick();
        test_lw_wait();
        test_extend();
        test_store();
        test_misaligned();
        test_ready_idle();
        test_reset_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL expose these ports, one per line (name direction width meaning):
 clk  in  1  single system clock, rising edge.
 reset_n  in  1  asynchronous, active-low reset.
 M_valid  in  1  instruction present in MEM stage.
 M_ins  in  32  MEM-stage instruction word.
 M_PC  in  32  MEM-stage PC, for exception reporting.
 M_alu_res  in  32  effective address from the execute stage.
 M_reg_rt  in  32  forwarded store data.
 mem_req  out  1  bus request.
 mem_we  out  1  bus write.
 mem_addr  out  32  word-aligned bus address.
 mem_wdata  out  32  lane-replicated store data.
 mem_byteen  out  4  byte enables.
 mem_ready  in  1  bus completion, one-cycle pulse.
 mem_rdata  in  32  read word, valid with mem_ready.
 M_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM registers.
 ld_valid  out  1  loaded data valid, one-cycle pulse.
 ld_data  out  32  extended load result.
 exc_adel  out  1  load address error pulse.
 exc_ades  out  1  store address error pulse.
 exc_pc  out  32  PC of the faulting instruction.

Function
REQ-002 The block SHALL decode from M_ins only lw, lh, lhu, lb, lbu, sw, sh and sb; every other opcode SHALL be a non-memory op.
REQ-003 For a non-memory op, or when M_valid=0, the block SHALL hold M_stall=0 and mem_req=0.
REQ-004 Alignment rule: a word access SHALL require addr[1:0]=0, a half access addr[0]=0, and a byte access SHALL have no constraint.
REQ-005 For a misaligned memory op, the block SHALL issue no bus request.
- It SHALL pulse exc_adel (load) or exc_ades (store) for exactly one cycle.
- exc_pc SHALL equal M_PC in that cycle.
- M_stall SHALL stay 0.
REQ-006 The FSM SHALL have the states IDLE and BUSY.
REQ-007 IDLE->BUSY SHALL occur on an aligned memory op with M_valid=1.
- On that edge the block SHALL register the address, the write flag, the byte enables, the store data and the load type.
REQ-008 In BUSY the block SHALL hold mem_req=1, and the bus outputs SHALL stay stable until mem_ready.
REQ-009 BUSY->IDLE SHALL occur on mem_ready=1, giving a minimum op latency of 2 cycles (issue cycle plus ready cycle).
REQ-010 M_stall SHALL be 1 in the issue cycle and in every BUSY cycle without mem_ready, and 0 in the BUSY cycle in which mem_ready=1.
- The instruction therefore leaves MEM on that edge.
REQ-011 Output encoding:
- mem_addr SHALL equal {addr[31:2],2'b00}.
- sw SHALL use byteen 1111.
- sh SHALL use 0011 or 1100 by addr[1].
- sb SHALL use one-hot 1<<addr[1:0].
- Store data SHALL be replicated across lanes: half to both halves, byte to all four.
REQ-012 Load extension:
- On the completing edge, ld_data SHALL receive the selected lane of mem_rdata.
- lb/lh SHALL sign-extend; lbu/lhu SHALL zero-extend; lw SHALL pass the word through.
- ld_valid SHALL pulse for one cycle after that edge.
REQ-013 A store SHALL never assert ld_valid.
REQ-014 The block SHALL ignore a mem_ready in IDLE, with no state change and no ld_valid.
REQ-015 Back-to-back memory ops SHALL be accepted:
- The next op's IDLE->BUSY SHALL occur no earlier than the cycle after completion.
- There SHALL be no combinational path from mem_ready to mem_req.

Reset
REQ-016 Asserting reset_n=0 SHALL, asynchronously:
- force state to IDLE;
- drive mem_req, mem_we, M_stall, ld_valid, exc_adel and exc_ades to 0;
- clear mem_addr, mem_wdata, mem_byteen, ld_data and exc_pc to 0.
REQ-017 Reset during BUSY SHALL abandon the transaction, and a mem_ready arriving later SHALL be ignored (REQ-014).
REQ-018 Reset deassertion SHALL take effect on the first rising clk edge, with no operation issued in that cycle unless the conditions of REQ-007 hold.

Structure
REQ-019 The following SHALL live in the shared macros file beside the existing instruction-field macros:
- opcode constants for the eight memory ops;
- the FSM state encodings;
- the load-type encoding (W, H, HU, B, BU).
REQ-020 Lane selection and extension SHALL be a combinational sub-module, load_ext, with inputs word, addr[1:0] and load type and output data[31:0].
REQ-021 Decode SHALL reuse the existing CU instance style, with no duplicated opcode tables.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- lw at 0x0000_1004, mem_ready after 3 cycles, rdata 0xDEADBEEF -> M_stall high 3 cycles, then ld_data=0xDEADBEEF and ld_valid pulse.
- lb at 0x...1003, rdata 0x80123456 -> ld_data=0xFFFFFF80; lbu at the same address -> 0x00000080.
- sh at 0x...1002, rt=0x0000ABCD -> mem_byteen=1100, mem_wdata=0xABCDABCD, mem_we=1, no ld_valid.
- lw at 0x...1001 -> exc_adel pulse, exc_pc=M_PC, mem_req never 1; sh at 0x...1001 -> exc_ades pulse.
- reset_n low during BUSY, stray mem_ready 2 cycles later -> state IDLE, all outputs 0, no ld_valid.
- sw immediately followed by lw with mem_ready at minimum latency -> two requests on separate cycles, correct byteen and data for each.
